// File: rtl/cam_capture_gen.sv
// rtl/cam_capture_gen.sv - RGB565 camera byte-stream capture to frame-buffer writes; optional colour bars under CAM_CAPTURE_TESTPAT_EN
module cam_capture_gen #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DECIM  = 1,
    parameter int CH_W   = 5,
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PCLK,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    input  logic              en,
    input  logic              test_pat,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic [ADDR_W-1:0] index,
    output logic              valid,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              overrun
);

    // Decimation is a power of two, so divide/modulo become shift/mask
    localparam int DSH = (DECIM == 4) ? 2 : ((DECIM == 2) ? 1 : 0);
    // Counters are wide enough to hold a value past the active window and saturate there
    localparam int XW  = $clog2(H_RES + 2) + 1;
    localparam int YW  = $clog2(V_RES + 2) + 1;
    localparam logic [XW-1:0] H_LIM  = XW'(H_RES);
    localparam logic [YW-1:0] V_LIM  = YW'(V_RES);
    localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
    localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

    state_t state, state_nxt;

    logic pclk_s1, pclk_s2, pclk_d;
    logic vsync_s1, vsync_s2, vsync_d;
    logic href_s1, href_s2, href_d;
    logic [7:0] d_s1, d_s2;

    logic pclk_rise, vsync_rise, vsync_fall, href_fall;
    logic frame_start, frame_end, capturing;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          phase;
    logic [7:0]    byte0;

    logic [4:0] r5, b5;
    logic [5:0] g6;
    logic [CH_W-1:0] pix_r, pix_g, pix_b;
    logic in_window, on_grid;

    // Two-flop synchronisers for the sensor signals plus one delay stage for edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pclk_s1  <= 1'b0;
            pclk_s2  <= 1'b0;
            pclk_d   <= 1'b0;
            vsync_s1 <= 1'b0;
            vsync_s2 <= 1'b0;
            vsync_d  <= 1'b0;
            href_s1  <= 1'b0;
            href_s2  <= 1'b0;
            href_d   <= 1'b0;
            d_s1     <= 8'd0;
            d_s2     <= 8'd0;
        end else begin
            pclk_s1  <= PCLK;
            pclk_s2  <= pclk_s1;
            pclk_d   <= pclk_s2;
            vsync_s1 <= VSYNC;
            vsync_s2 <= vsync_s1;
            vsync_d  <= vsync_s2;
            href_s1  <= HREF;
            href_s2  <= href_s1;
            href_d   <= href_s2;
            d_s1     <= D;
            d_s2     <= d_s1;
        end
    end

    assign pclk_rise  = pclk_s2 & ~pclk_d;
    assign vsync_rise = vsync_s2 & ~vsync_d;
    assign vsync_fall = ~vsync_s2 & vsync_d;
    assign href_fall  = ~href_s2 & href_d;

    // Capture state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and frame-event decode; dropping en aborts from any state
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        capturing   = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    state_nxt   = ACTIVE;
                    frame_start = en;
                end
            end
            ACTIVE: begin
                capturing = en;
                if (vsync_rise) begin
                    state_nxt = WAIT_FRAME;
                    frame_end = en;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // RGB565 unpack: byte0 holds R and upper G, the current byte completes the pixel
    assign r5 = byte0[7:3];
    assign g6 = {byte0[2:0], d_s2[7:5]};
    assign b5 = d_s2[4:0];

    assign in_window = (x < H_LIM) && (y < V_LIM);
    assign on_grid   = ((x & X_MASK) == '0) && ((y & Y_MASK) == '0);

`ifdef CAM_CAPTURE_TESTPAT_EN
    localparam int BAR_W = (H_RES / 8 < 1) ? 1 : H_RES / 8;
    logic [XW-1:0] bar_raw;
    logic [2:0]    bar;
    assign bar_raw = x / XW'(BAR_W);
    assign bar     = (bar_raw > XW'(7)) ? 3'd7 : bar_raw[2:0];
`else
    logic unused_test_pat;
    assign unused_test_pat = test_pat;
`endif

    // Pixel colour: sensor data truncated to CH_W, or the colour-bar pattern when selected
    always_comb begin
        pix_r = r5[4 -: CH_W];
        pix_g = g6[5 -: CH_W];
        pix_b = b5[4 -: CH_W];
`ifdef CAM_CAPTURE_TESTPAT_EN
        // Bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black
        if (test_pat) begin
            pix_r = {CH_W{~bar[1]}};
            pix_g = {CH_W{~bar[2]}};
            pix_b = {CH_W{~bar[0]}};
        end
`endif
    end

    // Byte/pixel/line counting, write strobe generation and frame bookkeeping
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            byte0      <= 8'd0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            index      <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            overrun    <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                x     <= '0;
                y     <= '0;
                phase <= 1'b0;
            end else if (frame_end) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
                phase      <= 1'b0;
            end else if (capturing) begin
                if (href_fall) begin
                    // End of line: any half pixel is dropped here
                    phase <= 1'b0;
                    x     <= '0;
                    if ((x != '0) && !(&y)) y <= y + 1'b1;
                end else if (pclk_rise && href_s2) begin
                    if (!phase) begin
                        byte0 <= d_s2;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!(&x)) x <= x + 1'b1;
                        if (in_window) begin
                            if (on_grid) begin
                                valid <= 1'b1;
                                red   <= pix_r;
                                green <= pix_g;
                                blue  <= pix_b;
                                index <= ADDR_W'(32'(y >> DSH) * 32'(H_RES / DECIM) + 32'(x >> DSH));
                            end
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
